ps2_key_sched: RTL
==================

Name: ps2_key_sched

Overview:
- Controller between the PS/2 frame receiver and the consumers of keyboard events (display, counters, text logic).
- Takes validated scan-code bytes and sequences the make/break/extended prefix protocol.
- Tracks the held key and a press counter, and flags typematic repeats.
- Queues complete key events in a small FIFO with a valid/ready handshake, and recovers from truncated sequences with an inter-byte timeout.

Parameters:
FIFO_DEPTH, 4, event queue entries; power of 2, ≥2
CNT_W, 16, press counter width
TIMEOUT, 100000, clk cycles allowed between bytes of one multi-byte sequence

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
rx_valid  in  1  one-cycle pulse: rx_data holds a frame with start, stop and parity already checked
rx_data  in  8  received scan-code byte
rx_err  in  1  one-cycle pulse: frame error detected by receiver
evt_valid  out  1  FIFO head valid
evt_ready  in  1  consumer accepts head when evt_valid & evt_ready
evt_code  out  8  key code (prefixes stripped)
evt_ext  out  1  key had E0 prefix
evt_break  out  1  1 = release, 0 = press
evt_repeat  out  1  make of the already-held key (typematic)
held  out  1  a key is currently held
held_code  out  9  {ext, code} of held key, 0 when none
press_cnt  out  CNT_W  count of non-repeat make events, wraps modulo 2^CNT_W
ovf  out  1  sticky: an event was dropped because the FIFO was full
clr  in  1  synchronous clear of press_cnt and ovf

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE, timer cleared, FIFO emptied.
  - evt_valid=0, evt_* = 0, held=0, held_code=0, press_cnt=0, ovf=0.
- Decode FSM acts only on cycles with rx_valid=1:
  - IDLE: F0 -> BRK; E0 -> EXT; 00 or FF -> dropped, stay IDLE; any other byte -> emit make {ext=0}, stay IDLE.
  - EXT: E0 -> stay EXT; F0 -> EXT_BRK; other -> emit make {ext=1}, go IDLE.
  - BRK: E0 or F0 -> protocol error, no event, go IDLE; other -> emit break {ext=0}, go IDLE.
  - EXT_BRK: E0 or F0 -> protocol error, go IDLE; other -> emit break {ext=1}, go IDLE.
- rx_err pulse in any state: go IDLE, timer cleared, no event. rx_err has priority over a simultaneous rx_valid.
- Timeout:
  - The timer runs while state != IDLE and is cleared on every rx_valid.
  - When it reaches TIMEOUT-1, the FSM goes to IDLE with no event.
- Emitting an event, all effects take place on the same edge that samples the final byte:
  - Make, with {ext,code} == held_code and held=1: evt_repeat=1, press_cnt unchanged.
  - Make, otherwise: evt_repeat=0, held<=1, held_code<={ext,code}, press_cnt += 1.
  - Break, matching held_code with held=1: held<=0, held_code<=0.
  - Break, not matching: held state unchanged. Break events always have evt_repeat=0.
- FIFO:
  - An event is pushed on the edge that samples the final byte. evt_valid rises the next cycle if the FIFO was empty (1-cycle latency).
  - Head outputs come straight from registered storage. evt_* = 0 while evt_valid=0.
  - Pop occurs when evt_valid & evt_ready. Popping when empty is ignored.
  - Full, push with no pop: the event is dropped and ovf<=1. held and press_cnt are still updated.
  - Full, push and pop in the same cycle: both proceed, no overflow.
  - Order is strict FIFO. Read and write pointers wrap modulo FIFO_DEPTH; full/empty are distinguished by an extra pointer bit.
- clr:
  - Zeroes press_cnt and ovf on the next edge.
  - Takes priority over a simultaneous increment or overflow set.
  - Does not affect the FIFO, FSM or held state.
- evt_ready is ignored while evt_valid=0. Holding evt_ready high continuously drains one event per cycle.

Test Plan:
1. Bytes 1C, then F0 1C, evt_ready=1 -> events {1C, ext0, brk0, rep0} then {1C, ext0, brk1}; press_cnt=1; held goes 1 then 0; held_code 01C then 000.
2. Bytes E0 75, then E0 F0 75 -> events {75, ext1, brk0} then {75, ext1, brk1}; held_code=175 between the two events.
3. Bytes 1C 1C 1C -> three make events with rep=0,1,1; press_cnt=1. Then 32 -> rep=0, press_cnt=2, held_code=032.
4. FIFO_DEPTH=4, evt_ready=0, makes 15 1D 24 2D 2C -> evt_valid=1, ovf=1, press_cnt=5. Then evt_ready=1 -> drains 15, 1D, 24, 2D in order. clr -> ovf=0, press_cnt=0.
5. Byte F0, then TIMEOUT idle cycles, then 1C -> make event (brk=0) for 1C. Byte E0, then rx_err, then 1C -> make with ext=0.
6. Async rst low mid-sequence after E0 F0, with 2 events queued -> evt_valid=0 immediately, all outputs 0. After release, 1C -> make {1C, ext0}.

Source files
------------

// File: rtl/ps2_key_sched.sv
// PS/2 key event scheduler: decodes make/break/E0 prefix sequences from
// validated scan-code bytes, tracks the held key and press count, flags
// typematic repeats, and queues complete events in a small FIFO.
module ps2_key_sched #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned TIMEOUT    = 100000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  input  logic             rx_err,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [7:0]       evt_code,
  output logic             evt_ext,
  output logic             evt_break,
  output logic             evt_repeat,
  output logic             held,
  output logic [8:0]       held_code,
  output logic [CNT_W-1:0] press_cnt,
  output logic             ovf,
  input  logic             clr
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [7:0] C_BRK = 8'hF0;
  localparam logic [7:0] C_EXT = 8'hE0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [TW-1:0]   r_timer;
  logic [TW-1:0]   w_timer_nxt;

  logic            w_emit;
  logic            w_emit_brk;
  logic            w_emit_ext;
  logic [8:0]      w_key;
  logic            w_match;
  logic            w_repeat;

  logic            r_held;
  logic [8:0]      r_held_code;
  logic [CNT_W-1:0] r_press_cnt;
  logic            r_ovf;

  logic [10:0]     r_mem [FIFO_DEPTH];
  logic [AW:0]     r_wr;
  logic [AW:0]     r_rd;
  logic            w_empty;
  logic            w_full;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;
  logic [10:0]     w_head;

  // Decode state and inter-byte timer register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  // Next-state decode: rx_err wins, then a received byte, then timeout
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = '0;
    w_emit      = 1'b0;
    w_emit_brk  = 1'b0;
    w_emit_ext  = 1'b0;
    if (rx_err) begin
      w_state_nxt = S_IDLE;
    end else if (rx_valid) begin
      unique case (r_state)
        S_IDLE: begin
          if (rx_data == C_BRK) begin
            w_state_nxt = S_BRK;
          end else if (rx_data == C_EXT) begin
            w_state_nxt = S_EXT;
          end else if (rx_data != 8'h00 && rx_data != 8'hFF) begin
            w_emit = 1'b1;
          end
        end
        S_EXT: begin
          if (rx_data == C_EXT) begin
            w_state_nxt = S_EXT;
          end else if (rx_data == C_BRK) begin
            w_state_nxt = S_EXT_BRK;
          end else begin
            w_emit      = 1'b1;
            w_emit_ext  = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        S_BRK: begin
          w_state_nxt = S_IDLE;
          if (rx_data != C_EXT && rx_data != C_BRK) begin
            w_emit     = 1'b1;
            w_emit_brk = 1'b1;
          end
        end
        S_EXT_BRK: begin
          w_state_nxt = S_IDLE;
          if (rx_data != C_EXT && rx_data != C_BRK) begin
            w_emit     = 1'b1;
            w_emit_brk = 1'b1;
            w_emit_ext = 1'b1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end else if (r_state != S_IDLE) begin
      if (r_timer == TW'(TIMEOUT - 1)) begin
        w_state_nxt = S_IDLE;
      end else begin
        w_timer_nxt = r_timer + TW'(1);
      end
    end
  end

  assign w_key    = {w_emit_ext, rx_data};
  assign w_match  = r_held && (r_held_code == w_key);
  assign w_repeat = w_emit && !w_emit_brk && w_match;

  // Held key tracking, press counter and sticky overflow (clr has priority)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_held      <= 1'b0;
      r_held_code <= '0;
      r_press_cnt <= '0;
      r_ovf       <= 1'b0;
    end else begin
      if (w_emit) begin
        if (!w_emit_brk) begin
          if (!w_match) begin
            r_held      <= 1'b1;
            r_held_code <= w_key;
          end
        end else if (w_match) begin
          r_held      <= 1'b0;
          r_held_code <= '0;
        end
      end
      if (clr) begin
        r_press_cnt <= '0;
        r_ovf       <= 1'b0;
      end else begin
        if (w_emit && !w_emit_brk && !w_match) begin
          r_press_cnt <= r_press_cnt + CNT_W'(1);
        end
        if (w_drop) begin
          r_ovf <= 1'b1;
        end
      end
    end
  end

  // Extra pointer bit separates full from empty when the indices coincide
  assign w_empty = (r_wr == r_rd);
  assign w_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_pop   = !w_empty && evt_ready;
  assign w_push  = w_emit && (!w_full || w_pop);
  assign w_drop  = w_emit && w_full && !w_pop;

  // FIFO pointers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + (AW+1)'(1);
      if (w_pop)  r_rd <= r_rd + (AW+1)'(1);
    end
  end

  // FIFO storage: {repeat, break, ext, code}
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr[AW-1:0]] <= {w_repeat, w_emit_brk, w_emit_ext, rx_data};
    end
  end

  assign w_head     = r_mem[r_rd[AW-1:0]];
  assign evt_valid  = !w_empty;
  assign evt_code   = w_empty ? 8'h00 : w_head[7:0];
  assign evt_ext    = !w_empty && w_head[8];
  assign evt_break  = !w_empty && w_head[9];
  assign evt_repeat = !w_empty && w_head[10];

  assign held      = r_held;
  assign held_code = r_held_code;
  assign press_cnt = r_press_cnt;
  assign ovf       = r_ovf;

endmodule
